control_store: RTL and testbench
================================

CONTROL_STORE -- requirements
Module: control_store

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 64, microcode ROM entries; minimum 50.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin one cosine computation.
REQ-005 SHALL have port A_vec  input  32  vector A, four unsigned 8-bit elements; element i = bits [8i+7:8i].
REQ-006 SHALL have port B_vec  input  32  vector B, same packing as A_vec.
REQ-007 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-008 SHALL have port cosine_similarity  output  16  result, unsigned Q1.15 (0x8000 = 1.0).

Function
REQ-009 SHALL be a microcoded engine: program counter pc indexes a 32-bit micro_word ROM; fields drive operand-select muxes, multiplier, accumulator (clear / load), integer sqrt, divider and two 3-entry result register files.
REQ-010 SHALL have two states: IDLE and BUSY; internal busy = (state == BUSY).
REQ-011 In IDLE with start=1 at a rising edge: SHALL capture A_vec/B_vec into internal registers, set pc=0 and enter BUSY; inputs are ignored afterwards.
REQ-012 start while BUSY SHALL be ignored; start held high after done SHALL launch a new computation.
REQ-013 SHALL compute dot = sum a_i*b_i, nA = sum a_i^2, nB = sum b_i^2, 8x8 unsigned products, 18-bit accumulations.
REQ-014 SHALL compute P = nA*nB (36 bits) and S = floor(sqrt(P)) (18 bits) with a 1-bit/cycle restoring square root.
REQ-015 SHALL compute cosine_similarity = floor((dot << 15) / S) with a 1-bit/cycle restoring divider.
REQ-016 Schedule: 12 MAC microinstructions, 1 product, 18 sqrt steps, 17 divide steps; done SHALL assert exactly 50 cycles after the start-sampling edge, independent of data.
REQ-017 Result SHALL never exceed 0x8000, which holds by Cauchy-Schwarz with floor sqrt.
REQ-018 Result SHALL update on the same edge that raises done and hold until the next done.
REQ-019 done SHALL be high for exactly one cycle; SHALL then return to IDLE with pc=0.

Reset
REQ-020 reset=0 SHALL immediately force IDLE, pc=0, done=0, cosine_similarity=0 and clear accumulator, operand registers and register files.
REQ-021 reset asserted mid-computation SHALL abort it with no done pulse; a new start is required after release.

Configuration
REQ-022 Macro CONTROL_STORE_ZERO_GUARD_EN defined: if S==0 (either vector all-zero), result SHALL be 0x0000.
REQ-023 Macro CONTROL_STORE_ZERO_GUARD_EN undefined: S==0 SHALL yield the raw restoring-divider quotient 0xFFFF; latency is unchanged either way.

Verification
REQ-024 A=0x04030201, B=0x08070605, start pulsed -> done 50 cycles later, cosine_similarity=31857 (0x7C71).
REQ-025 A=B=0x01010101 -> cosine_similarity=0x8000.
REQ-026 A=0x00000001, B=0x00000100 (orthogonal) -> cosine_similarity=0x0000.
REQ-027 A=0x00000000, B=0x08070605 -> 0x0000 with macro defined, 0xFFFF without.
REQ-028 Second start 10 cycles into a run -> ignored, single done at cycle 50; reset at cycle 20 -> no done, outputs 0.

Source files
------------

// File: rtl/control_store.sv
// Microcoded cosine-similarity engine: MAC, restoring sqrt and restoring divide driven from a micro-word ROM.
// Optional: define CONTROL_STORE_ZERO_GUARD_EN to force a 0x0000 result when either vector is all-zero.
module control_store #(
   parameter int ROM_DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] A_vec,
   input  logic [31:0] B_vec,
   output logic        done,
   output logic [15:0] cosine_similarity
);
   // state | meaning
   // IDLE  | waiting for start, pc held at 0
   // BUSY  | stepping pc through the micro-program, one micro-word per cycle
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [3:0] OP_NOP = 4'd0, OP_MAC = 4'd1, OP_PROD = 4'd2, OP_SQRT = 4'd3,
                          OP_DIV = 4'd4, OP_WB = 4'd5, OP_FIN = 4'd6;
   localparam int PCW = $clog2(ROM_DEPTH);

   // Micro-word: [3:0] op, [4] x_src(B), [6:5] x_idx, [7] y_src(B), [9:8] y_idx,
   // [10] acc_clr, [11] acc_wr, [13:12] rf_idx, [14] sqrt_last, [31:15] reserved
   function automatic logic [31:0] rom_word(input logic [PCW-1:0] addr);
      int          a;
      logic [31:0] w;
      a = int'(addr);
      w = '0;
      if (a < 12) begin
         w[3:0]   = OP_MAC;
         w[4]     = (a / 4 == 2);
         w[6:5]   = 2'(a % 4);
         w[7]     = (a / 4 != 1);
         w[9:8]   = 2'(a % 4);
         w[10]    = (a % 4 == 0);
         w[11]    = (a % 4 == 3);
         w[13:12] = 2'(a / 4);
      end else if (a == 12) begin
         w[3:0] = OP_PROD;
      end else if (a <= 30) begin
         w[3:0] = OP_SQRT;
         w[14]  = (a == 30);
      end else if (a <= 47) begin
         w[3:0] = OP_DIV;
      end else if (a == 48) begin
         w[3:0] = OP_WB;
      end else if (a == 49) begin
         w[3:0] = OP_FIN;
      end
      return w;
   endfunction

   state_t       state, state_nx;
   logic [PCW-1:0] pc;
   logic [31:0]  micro_word;
   logic [3:0]   uop;
   logic         busy, fin;
   logic [31:0]  a_reg, b_reg;
   logic [17:0]  acc, acc_nx;
   logic [17:0]  rf_sum [3];
   logic [17:0]  rf_res [3];
   logic [7:0]   x_byte, y_byte;
   logic [15:0]  prod;
   logic [35:0]  sq_rad;
   logic [19:0]  sq_rem;
   logic [17:0]  sq_root, sq_root_nx;
   logic [21:0]  sq_rem_t, sq_trial;
   logic         sq_ge;
   logic [18:0]  dv_rem;
   logic [19:0]  dv_rem_t, dv_s;
   logic [16:0]  dv_num, dv_q;
   logic         dv_ge;
   logic [15:0]  q_sat, q_final, cos_q;

   assign busy       = (state == BUSY);
   assign micro_word = rom_word(pc);
   // A word with reserved bits set is treated as a no-op rather than guessed at.
   assign uop        = (busy && !(|micro_word[31:15])) ? micro_word[3:0] : OP_NOP;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      fin      = 1'b0;
      case (state)
         IDLE: if (start) state_nx = BUSY;
         BUSY: if (uop == OP_FIN) begin
            fin      = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      x_byte     = micro_word[4] ? b_reg[{micro_word[6:5], 3'b000} +: 8] : a_reg[{micro_word[6:5], 3'b000} +: 8];
      y_byte     = micro_word[7] ? b_reg[{micro_word[9:8], 3'b000} +: 8] : a_reg[{micro_word[9:8], 3'b000} +: 8];
      prod       = x_byte * y_byte;
      acc_nx     = (micro_word[10] ? 18'd0 : acc) + {2'b00, prod};
      sq_rem_t   = {sq_rem, sq_rad[35:34]};
      sq_trial   = {2'b00, sq_root, 2'b01};
      sq_ge      = (sq_rem_t >= sq_trial);
      sq_root_nx = {sq_root[16:0], sq_ge};
      dv_s       = {2'b00, rf_res[0]};
      dv_rem_t   = {dv_rem, dv_num[16]};
      dv_ge      = (dv_rem_t >= dv_s);
      // S == 0 drives every quotient bit to 1, so saturation yields 0xFFFF there.
      q_sat      = dv_q[16] ? 16'hFFFF : dv_q[15:0];
`ifdef CONTROL_STORE_ZERO_GUARD_EN
      q_final    = (rf_res[0] == 18'd0) ? 16'h0000 : q_sat;
`else
      q_final    = q_sat;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         acc     <= '0;
         sq_rad  <= '0;
         sq_rem  <= '0;
         sq_root <= '0;
         dv_rem  <= '0;
         dv_num  <= '0;
         dv_q    <= '0;
         cos_q   <= '0;
         done    <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            rf_sum[i] <= '0;
            rf_res[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         if (!busy) begin
            if (start) begin
               a_reg <= A_vec;
               b_reg <= B_vec;
               pc    <= '0;
            end
         end else begin
            pc <= fin ? '0 : pc + 1'b1;
            case (uop)
               OP_MAC: begin
                  acc <= acc_nx;
                  if (micro_word[11] && micro_word[13:12] != 2'd3) rf_sum[micro_word[13:12]] <= acc_nx;
               end
               OP_PROD: begin
                  sq_rad  <= rf_sum[1] * rf_sum[2];
                  sq_rem  <= '0;
                  sq_root <= '0;
                  // dot <= S, so the top quotient bits of (dot << 15) are pre-aligned here.
                  dv_rem  <= {3'b000, rf_sum[0][17:2]};
                  dv_num  <= {rf_sum[0][1:0], 15'd0};
                  dv_q    <= '0;
               end
               OP_SQRT: begin
                  sq_rem  <= sq_ge ? 20'(sq_rem_t - sq_trial) : sq_rem_t[19:0];
                  sq_root <= sq_root_nx;
                  sq_rad  <= {sq_rad[33:0], 2'b00};
                  if (micro_word[14]) rf_res[0] <= sq_root_nx;
               end
               OP_DIV: begin
                  dv_rem <= dv_ge ? 19'(dv_rem_t - dv_s) : dv_rem_t[18:0];
                  dv_q   <= {dv_q[15:0], dv_ge};
                  dv_num <= {dv_num[15:0], 1'b0};
               end
               OP_WB: begin
                  rf_res[1] <= {1'b0, dv_q};
                  rf_res[2] <= {2'b00, q_final};
               end
               OP_FIN: begin
                  cos_q <= rf_res[2][15:0];
                  done  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign cosine_similarity = cos_q;
endmodule

// File: tb/tb_control_store.sv
// Bench for control_store: randomized vectors against an arithmetic cosine model, plus latency/start/reset scenarios.
module tb_control_store;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] A_vec, B_vec;
   logic        done;
   logic [15:0] cosine_similarity;
   int          checks = 0;
   int          errors = 0;

`ifdef CONTROL_STORE_ZERO_GUARD_EN
   localparam logic [15:0] ZERO_RES = 16'h0000;
`else
   localparam logic [15:0] ZERO_RES = 16'hFFFF;
`endif

   control_store #(.ROM_DEPTH(64)) dut (
      .clk(clk), .reset(reset), .start(start), .A_vec(A_vec), .B_vec(B_vec),
      .done(done), .cosine_similarity(cosine_similarity)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_cos(input logic [31:0] a, input logic [31:0] b);
      longint dot, na, nb, p, s, x, y;
      dot = 0; na = 0; nb = 0;
      for (int i = 0; i < 4; i++) begin
         x = longint'(a[8*i +: 8]);
         y = longint'(b[8*i +: 8]);
         dot += x * y;
         na  += x * x;
         nb  += y * y;
      end
      p = na * nb;
      s = longint'($sqrt(real'(p)));
      while (s * s > p) s--;
      while ((s + 1) * (s + 1) <= p) s++;
      if (s == 0) return ZERO_RES;
      return 16'((dot * 32768) / s);
   endfunction

   // Launches one computation and waits (bounded) for done; lat = -1 if it never came.
   task automatic do_run(input logic [31:0] a, input logic [31:0] b, output int lat, output logic [15:0] res);
      @(negedge clk);
      start = 1'b1; A_vec = a; B_vec = b;
      @(posedge clk); #1;
      start = 1'b0; A_vec = $urandom; B_vec = $urandom;
      lat = -1; res = 16'hxxxx;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = c;
            res = cosine_similarity;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; A_vec = '0; B_vec = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++;
      if (cosine_similarity !== 16'h0000) begin errors++; $display("FAIL reset_cos: got %h expected 0000", cosine_similarity); end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] ta [4] = '{32'h04030201, 32'h01010101, 32'h00000001, 32'h00000000};
      logic [31:0] tb [4] = '{32'h08070605, 32'h01010101, 32'h00000100, 32'h08070605};
      logic [15:0] te [4];
      int lat;
      logic [15:0] res;
      te = '{16'h7C71, 16'h8000, 16'h0000, ZERO_RES};
      for (int i = 0; i < 4; i++) begin
         do_run(ta[i], tb[i], lat, res);
         checks++;
         if (lat != 50) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 50", i, lat); end
         checks++;
         if (res !== te[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, te[i]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [15:0] exp, res;
      int lat;
      for (int i = 0; i < 16; i++) begin
         a = $urandom; b = $urandom;
         if (i % 5 == 4) b = '0;
         if (i % 7 == 3) b = a;
         exp = ref_cos(a, b);
         do_run(a, b, lat, res);
         checks++;
         if (lat != 50) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected 50", i, lat); end
         checks++;
         if (res !== exp) begin errors++; $display("FAIL random_result[%0d] A=%h B=%h: got %h expected %h", i, a, b, res, exp); end
      end
   endtask

   task automatic test_pulse_hold();
      logic [31:0] a, b;
      logic [15:0] res;
      int lat, extra_done;
      a = 32'h10203040; b = 32'h05FF0A80;
      do_run(a, b, lat, res);
      extra_done = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done) extra_done++;
      end
      checks++;
      if (extra_done != 0) begin errors++; $display("FAIL pulse_width: got %0d extra done cycles expected 0", extra_done); end
      checks++;
      if (cosine_similarity !== ref_cos(a, b)) begin errors++; $display("FAIL result_hold: got %h expected %h", cosine_similarity, ref_cos(a, b)); end
   endtask

   task automatic test_ignore_start();
      logic [31:0] a, b;
      int ndone, first;
      logic [15:0] res;
      a = 32'hC8641E0A; b = 32'h0F1E2D3C;
      @(negedge clk);
      start = 1'b1; A_vec = a; B_vec = b;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; first = -1; res = '0;
      for (int c = 1; c <= 70; c++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (first < 0) begin first = c; res = cosine_similarity; end
         end
         start = (c == 9);
         A_vec = $urandom; B_vec = $urandom;
      end
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL ignore_start_count: got %0d expected 1", ndone); end
      checks++;
      if (first != 50) begin errors++; $display("FAIL ignore_start_latency: got %0d expected 50", first); end
      checks++;
      if (res !== ref_cos(a, b)) begin errors++; $display("FAIL ignore_start_result: got %h expected %h", res, ref_cos(a, b)); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2;
      int t1, t2, nd;
      logic [15:0] r1, r2;
      a1 = $urandom | 32'h01; b1 = $urandom | 32'h01;
      a2 = $urandom | 32'h0100; b2 = $urandom | 32'h0100;
      @(negedge clk);
      start = 1'b1; A_vec = a1; B_vec = b1;
      @(posedge clk); #1;
      A_vec = a2; B_vec = b2;
      t1 = -1; t2 = -1; nd = 0; r1 = '0; r2 = '0;
      for (int c = 1; c <= 120; c++) begin
         @(posedge clk); #1;
         if (done) begin
            nd++;
            if (t1 < 0) begin t1 = c; r1 = cosine_similarity; end
            else if (t2 < 0) begin t2 = c; r2 = cosine_similarity; end
         end
         if (c == 51) start = 1'b0;
      end
      checks++;
      if (nd != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", nd); end
      checks++;
      if (t1 != 50 || t2 != 101) begin errors++; $display("FAIL b2b_timing: got %0d,%0d expected 50,101", t1, t2); end
      checks++;
      if (r1 !== ref_cos(a1, b1)) begin errors++; $display("FAIL b2b_result1: got %h expected %h", r1, ref_cos(a1, b1)); end
      checks++;
      if (r2 !== ref_cos(a2, b2)) begin errors++; $display("FAIL b2b_result2: got %h expected %h", r2, ref_cos(a2, b2)); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] a, b;
      int lat, nd;
      logic [15:0] res;
      do_run(32'h01010101, 32'h01010101, lat, res);
      a = 32'h11223344; b = 32'h55667788;
      @(negedge clk);
      start = 1'b1; A_vec = a; B_vec = b;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checks++;
      if (done !== 1'b0 || cosine_similarity !== 16'h0000) begin
         errors++; $display("FAIL abort_immediate: got done=%b cos=%h expected done=0 cos=0000", done, cosine_similarity);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      nd = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      checks++;
      if (nd != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", nd); end
      checks++;
      if (cosine_similarity !== 16'h0000) begin errors++; $display("FAIL abort_cos: got %h expected 0000", cosine_similarity); end
      do_run(a, b, lat, res);
      checks++;
      if (lat != 50 || res !== ref_cos(a, b)) begin
         errors++; $display("FAIL abort_restart: got lat=%0d res=%h expected lat=50 res=%h", lat, res, ref_cos(a, b));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_pulse_hold();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
